// File: rtl/psram_xfer_arb.sv
// -----------------------------------------------------------------------------
// psram_xfer_arb
//
// Arbitrates between the two PSRAM requesters (cfg = APB configuration path,
// bus = AXI4 slave FSM) and sequences one transfer at a time onto the single
// psram_core transfer port. A granted command is latched, offered to the core
// with a valid/ready handshake, then the block waits for the core's done pulse
// (or a timeout), returns read data with a done/err pulse to the owner, and
// holds off the next grant for a programmable recovery gap.
//
// Parameters
//   FIXED_PRIO   0: round-robin on ties, 1: cfg always wins ties
//   TIMEOUT_CYC  cycles allowed in WAIT before the transfer ends with err=1
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   en_i                         arbitration enable (only gates new grants)
//   recy_i[7:0]                  recovery gap, sampled when a transfer ends
//   cfg_req_i/rdwr/addr/wdata    cfg command (level request, 1 = read)
//   cfg_done_o/err_o/rdata_o     cfg completion pulse, timeout flag, read byte
//   bus_req_i/rdwr/addr/wdata/mask  bus command (level request, 1 = read)
//   bus_done_o/err_o/rdata_o     bus completion pulse, timeout flag, read data
//   xfer_valid_o, xfer_ready_i   transfer handshake towards the core
//   xfer_rdwr/cflg/addr/wdata/mask_o  latched command fields
//   xfer_done_i, xfer_rdata_i    core completion pulse and read data
//   busy_o                       high whenever the sequencer is not idle
//   owner_o                      last or current grant (1 = cfg)
// -----------------------------------------------------------------------------
module psram_xfer_arb #(
   parameter bit FIXED_PRIO  = 1'b0,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [7:0]  recy_i,
   input  logic        cfg_req_i,
   input  logic        cfg_rdwr_i,
   input  logic [31:0] cfg_addr_i,
   input  logic [7:0]  cfg_wdata_i,
   output logic        cfg_done_o,
   output logic        cfg_err_o,
   output logic [7:0]  cfg_rdata_o,
   input  logic        bus_req_i,
   input  logic        bus_rdwr_i,
   input  logic [31:0] bus_addr_i,
   input  logic [63:0] bus_wdata_i,
   input  logic [7:0]  bus_mask_i,
   output logic        bus_done_o,
   output logic        bus_err_o,
   output logic [63:0] bus_rdata_o,
   output logic        xfer_valid_o,
   input  logic        xfer_ready_i,
   output logic        xfer_rdwr_o,
   output logic        xfer_cflg_o,
   output logic [31:0] xfer_addr_o,
   output logic [63:0] xfer_wdata_o,
   output logic [7:0]  xfer_mask_o,
   input  logic        xfer_done_i,
   input  logic [63:0] xfer_rdata_i,
   output logic        busy_o,
   output logic        owner_o
);

   // Timeout counter is wide enough to hold TIMEOUT_CYC itself so it can
   // saturate without wrapping back into the timeout comparison.
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TO_MAX  = {TW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RECY
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [TW-1:0] to_cnt;
   logic [7:0]    recy_cnt;
   logic          owner;

   logic          grant;
   logic          pick_cfg;
   logic          xfer_end;
   logic          timeout_hit;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the one-cycle decisions the datapath acts on:
   // grant/pick_cfg in IDLE, xfer_end/timeout_hit in WAIT. A core done that
   // lands on the timeout cycle is treated as a normal completion.
   always_comb begin
      state_next  = state;
      grant       = 1'b0;
      pick_cfg    = 1'b0;
      xfer_end    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en_i && (cfg_req_i || bus_req_i)) begin
               grant      = 1'b1;
               state_next = ST_ISSUE;
               if (cfg_req_i && bus_req_i) begin
                  pick_cfg = FIXED_PRIO ? 1'b1 : ~owner;
               end else begin
                  pick_cfg = cfg_req_i;
               end
            end
         end
         ST_ISSUE: begin
            if (xfer_ready_i) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (xfer_done_i) begin
               xfer_end   = 1'b1;
               state_next = ST_RECY;
            end else if (to_cnt == TO_LAST) begin
               xfer_end    = 1'b1;
               timeout_hit = 1'b1;
               state_next  = ST_RECY;
            end
         end
         ST_RECY: begin
            if (recy_cnt == 8'd0) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: command latch, counters and registered outputs. Valid and busy
   // are registered from the next state so they line up with the state
   // register without any combinational decode on the outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner        <= 1'b0;
         to_cnt       <= '0;
         recy_cnt     <= 8'd0;
         xfer_valid_o <= 1'b0;
         xfer_rdwr_o  <= 1'b0;
         xfer_addr_o  <= 32'd0;
         xfer_wdata_o <= 64'd0;
         xfer_mask_o  <= 8'd0;
         busy_o       <= 1'b0;
         cfg_done_o   <= 1'b0;
         cfg_err_o    <= 1'b0;
         cfg_rdata_o  <= 8'd0;
         bus_done_o   <= 1'b0;
         bus_err_o    <= 1'b0;
         bus_rdata_o  <= 64'd0;
      end else begin
         cfg_done_o   <= 1'b0;
         cfg_err_o    <= 1'b0;
         bus_done_o   <= 1'b0;
         bus_err_o    <= 1'b0;
         xfer_valid_o <= (state_next == ST_ISSUE);
         busy_o       <= (state_next != ST_IDLE);

         if (grant) begin
            owner <= pick_cfg;
            if (pick_cfg) begin
               xfer_rdwr_o  <= cfg_rdwr_i;
               xfer_addr_o  <= cfg_addr_i;
               xfer_wdata_o <= {56'd0, cfg_wdata_i};
               xfer_mask_o  <= 8'h01;
            end else begin
               xfer_rdwr_o  <= bus_rdwr_i;
               xfer_addr_o  <= bus_addr_i;
               xfer_wdata_o <= bus_wdata_i;
               xfer_mask_o  <= bus_mask_i;
            end
         end

         if (state == ST_ISSUE && xfer_ready_i) begin
            to_cnt <= '0;
         end else if (state == ST_WAIT && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TW'(1);
         end

         if (xfer_end) begin
            recy_cnt <= recy_i;
            if (owner) begin
               cfg_done_o <= 1'b1;
               cfg_err_o  <= timeout_hit;
               if (!timeout_hit) begin
                  cfg_rdata_o <= xfer_rdata_i[7:0];
               end
            end else begin
               bus_done_o <= 1'b1;
               bus_err_o  <= timeout_hit;
               if (!timeout_hit) begin
                  bus_rdata_o <= xfer_rdata_i;
               end
            end
         end else if (state == ST_RECY && recy_cnt != 8'd0) begin
            recy_cnt <= recy_cnt - 8'd1;
         end
      end
   end

   assign owner_o     = owner;
   assign xfer_cflg_o = owner;

endmodule

// File: doc/psram_xfer_arb.md
# psram_xfer_arb

Transfer arbiter and sequencer that sits between the two PSRAM requesters and the single `psram_core` transfer port. The requesters are the APB configuration path (cflg register accesses) and the AXI4 slave FSM (bus accesses). The block grants one requester at a time and latches its command. It drives the core's valid/rdwr/address/data handshake, waits for completion or a timeout, and returns read data with a done/err pulse. It then enforces a programmable recovery gap before the next grant.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes the cfg requester always win ties.
- `TIMEOUT_CYC`, default 4096: cycles allowed in WAIT before a transfer is aborted with an error. Must be ≥1.
- `clk_i`  in  1: single clock. All logic is on the rising edge.
- `rst_i`  in  1: reset, synchronous and active-high.
- `en_i`  in  1: arbitration enable. While 0, no new grants are issued; an in-flight transfer completes.
- `recy_i`  in  8: recovery gap in cycles, sampled on entry to RECY.
- `cfg_req_i`  in  1: cfg request level. Hold it, with its fields stable, until `cfg_done_o`.
- `cfg_rdwr_i`  in  1: 1 = read, 0 = write.
- `cfg_addr_i`  in  32: cfg address.
- `cfg_wdata_i`  in  8: cfg write byte.
- `cfg_done_o`  out  1: one-cycle completion pulse.
- `cfg_err_o`  out  1: qualifies `cfg_done_o`; 1 = timeout.
- `cfg_rdata_o`  out  8: read byte. Valid while `cfg_done_o` is high and held until the next cfg done.
- `bus_req_i`, `bus_rdwr_i`, `bus_addr_i[31:0]`  in: bus request level, direction and address. Same rules as cfg.
- `bus_wdata_i`  in  64: bus write data.
- `bus_mask_i`  in  8: bus byte write mask.
- `bus_done_o`, `bus_err_o`  out  1: bus completion pulse and error qualifier.
- `bus_rdata_o`  out  64: bus read data. Same validity and hold rules as `cfg_rdata_o`.
- `xfer_valid_o`  out  1: transfer request to the core.
- `xfer_ready_i`  in  1: core accepts the transfer when `xfer_valid_o && xfer_ready_i`.
- `xfer_rdwr_o`  out  1: latched direction.
- `xfer_cflg_o`  out  1: 1 = current owner is cfg.
- `xfer_addr_o`  out  32: latched address.
- `xfer_wdata_o`  out  64: latched write data.
- `xfer_mask_o`  out  8: latched byte mask.
- `xfer_done_i`  in  1: core completion pulse.
- `xfer_rdata_i`  in  64: core read data, valid with `xfer_done_i`.
- `busy_o`  out  1: high whenever the state is not IDLE.
- `owner_o`  out  1: last or current grant; 1 = cfg.

## Operation
- States: IDLE, ISSUE, WAIT, RECY.
- **IDLE:**
  - Requires `en_i` and at least one request.
  - Winner selection: if only one requester is active, it wins. If both are active, `FIXED_PRIO=1` picks cfg; otherwise the requester that is not `owner_o` wins.
  - Latch rdwr, addr, data, mask and the owner, then go to ISSUE.
  - cfg write data is zero-extended to 64 bits; the cfg mask is forced to 8'h01.
- **ISSUE:** hold `xfer_valid_o`=1 until `xfer_ready_i`=1. On that edge go to WAIT, clear the timeout counter and drop valid.
- **WAIT:**
  - On `xfer_done_i`: capture `xfer_rdata_i` into the owner's rdata register (cfg takes bits [7:0]). Pulse the owner's done with err=0 and go to RECY.
  - If the counter reaches `TIMEOUT_CYC-1` without done: pulse done with err=1, leave rdata unchanged, and go to RECY.
  - If `xfer_done_i` and the timeout land on the same cycle, done wins (err=0).
- **RECY:** load `recy_i` into an 8-bit down-counter. Return to IDLE when it is 0 (`recy_i`=0 gives a single RECY cycle).
- Latched fields are the only source of the `xfer_*` outputs. If a requester deasserts `req` after the grant, its transfer still completes and still emits done.
- The timeout counter is `$clog2(TIMEOUT_CYC+1)` bits, saturating, and counts only in WAIT.
- `en_i` falling during ISSUE or WAIT does not abort the transfer.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0: `xfer_*`, `*_done_o`, `*_err_o`, `*_rdata_o`, `busy_o`, `owner_o`.
  - `owner_o`=0, so the first tie goes to cfg.
  - Counters are 0.
- Reset asserted in any state returns to IDLE on the next edge. No done pulse is emitted for the aborted transfer.
- Grant latency: request seen in IDLE at edge N gives `xfer_valid_o`=1 from cycle N+1. The earliest acceptance edge is N+1.
- Completion: `xfer_done_i` high at edge M gives `*_done_o`=1 during cycle M+1 only. The state is RECY in that same cycle.
- Back-to-back: with `recy_i`=R, the next `xfer_valid_o` rises no earlier than R+2 cycles after the done pulse.
- All outputs are registered; there is no combinational path from `*_req_i` to `xfer_*`.

## Test plan
- **Single cfg read:** `cfg_req_i`=1, addr 0x10. Core returns ready after 2 cycles and done with rdata 0x..A5 after 5 more. Required: `xfer_cflg_o`=1, `xfer_rdwr_o`=1, then `cfg_done_o` pulses for 1 cycle with `cfg_rdata_o`=0xA5 and `cfg_err_o`=0.
- **Round-robin:** both requests held continuously with `recy_i`=0. Required: grants alternate cfg, bus, cfg, bus, with each `xfer_valid_o` rise exactly 2 cycles after the previous done pulse. With `FIXED_PRIO=1`, every grant goes to cfg.
- **Timeout:** `TIMEOUT_CYC`=16, bus write, core never pulses done. Required: `bus_done_o`=1 and `bus_err_o`=1 exactly 16 cycles after acceptance; `bus_rdata_o` unchanged; IDLE reached after the recovery gap.
- **Done coincident with timeout:** done arrives exactly on the timeout cycle. Required: err=0 and rdata captured.
- **Recovery and enable:** `recy_i`=5 with back-to-back bus writes gives a 7-cycle done-to-valid spacing. Dropping `en_i` during WAIT still completes the transfer; no new grant is issued until `en_i`=1.
- **Reset mid-WAIT:** assert `rst_i` for 1 cycle. Required: all outputs 0 on the next cycle, no done pulse, and a fresh request is granted normally afterwards.
